// File: rtl/seg7_scan_display.sv
// seg7_scan_display: loads a binary value via valid/ready, converts it to BCD
// with a one-bit-per-clock shift-add-3 engine, and time-multiplexes the held
// digits onto a shared seven-segment bus with one enable line per digit.
module seg7_scan_display #(
  parameter int WIDTH          = 8,
  parameter int DIGITS         = 3,
  parameter int SCAN_DIV       = 4,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  value_valid,
  input  logic [WIDTH-1:0]      value,
  output logic                  ready,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   digits_bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [SW-1:0]     SLOT_LAST  = SW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF    = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF     = ACTIVE_LOW_AN ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
  // The early return keeps p below 2^WIDTH before each multiply, so the
  // WIDTH+4 bit product never overflows.
  function automatic bit digits_fit();
    logic [WIDTH+3:0] p;
    logic [WIDTH+3:0] max_v;
    max_v = {4'b0000, {WIDTH{1'b1}}};
    p     = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (p > max_v) return 1'b1;
      p = p * 4'd10;
    end
    return p > max_v;
  endfunction

  if (DIGITS < 1)    begin : g_bad_digits   $error("DIGITS must be at least 1");        end
  if (SCAN_DIV < 1)  begin : g_bad_div      $error("SCAN_DIV must be at least 1");      end
  if (!digits_fit()) begin : g_bad_capacity $error("DIGITS too small for WIDTH bits");  end

  // Canonical active-high pattern {A,B,C,D,E,F,G}; non-decimal codes are dark.
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BW-1:0]     work_q,  work_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic [BW-1:0]     disp_q,  disp_d;
  logic [BW-1:0]     adj;

  logic [PW-1:0]     presc_q, presc_d;
  logic [SW-1:0]     slot_q,  slot_d;
  logic [6:0]        seg_q,   seg_d;
  logic [DIGITS-1:0] an_q,    an_d;
  logic [DIGITS-1:0] blank;
  logic              upper_zero;
  logic [3:0]        cur_digit;
  logic              cur_blank;
  logic [6:0]        pat;
  logic [DIGITS-1:0] onehot;
  logic              tick;

  assign ready      = (state_q == S_IDLE);
  assign digits_bcd = disp_q;
  assign seg        = seg_q;
  assign an         = an_q;

  // Converter next-state: accept, shift-add-3 per bit, then commit the result.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    adj     = work_q;
    case (state_q)
      S_IDLE: begin
        if (value_valid) begin
          shift_d = value;
          work_d  = '0;
          cnt_d   = CW'(WIDTH);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
        end
        {work_d, shift_d} = {adj, shift_q} << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        disp_d  = work_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Converter and display register state.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the display register is explicitly cleared on reset, so an aborted
  // conversion can never leave a partial result visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
    end
  end

  // Leading-zero mask: digit i>0 is dark when it and all higher digits are 0.
  always_comb begin
    upper_zero = 1'b1;
    blank      = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (disp_q[4*i +: 4] == 4'd0);
      if (BLANK_LZ && (i > 0) && upper_zero) blank[i] = 1'b1;
    end
  end

  // Scanner next-state: prescaler tick selects one digit and latches its pattern.
  always_comb begin
    presc_d   = presc_q + 1'b1;
    slot_d    = slot_q;
    seg_d     = seg_q;
    an_d      = an_q;
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    onehot    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (slot_q == SW'(i)) begin
        cur_digit = disp_q[4*i +: 4];
        cur_blank = blank[i];
        onehot[i] = 1'b1;
      end
    end
    pat  = cur_blank ? 7'b0000000 : seg_pattern(cur_digit);
    tick = (presc_q == PRESC_LAST);
    if (tick) begin
      presc_d = '0;
      slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
      seg_d   = ACTIVE_LOW_SEG ? ~pat : pat;
      an_d    = ACTIVE_LOW_AN ? ~onehot : onehot;
    end
  end

  // Scanner state and registered display outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      slot_q  <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      presc_q <= presc_d;
      slot_q  <= slot_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display at its default parameters
// (8-bit value, 3 digits, 4-cycle scan slot, active-low outputs, blanking on).
module tb_seg7_scan_display;

  logic        clk;
  logic        rst;
  logic        value_valid;
  logic [7:0]  value;
  logic        ready;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic [11:0] digits_bcd;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;  // rising edges since the last reset release

  seg7_scan_display #(
    .WIDTH(8), .DIGITS(3), .SCAN_DIV(4),
    .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1), .BLANK_LZ(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value_valid(value_valid),
    .value(value),
    .ready(ready),
    .seg(seg),
    .an(an),
    .digits_bcd(digits_bcd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic clk_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present value for exactly one edge (the accept edge e0).
  task automatic accept(input logic [7:0] v);
    value_valid = 1'b1;
    value       = v;
    clk_edge();
    value_valid = 1'b0;
    value       = ~v;
  endtask

  // Wait (bounded) for the converter to return to idle.
  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (ready === 1'b1) break;
      clk_edge();
    end
    check("ready_rise", {15'd0, ready}, 16'd1);
  endtask

  // Advance to just after the tick edge that presents the given slot.
  // Ticks land on edges 4,8,12,... after release; tick k shows slot (k-1)%3.
  task automatic wait_slot(input int s);
    do clk_edge();
    while (!((cyc % 4 == 0) && (((cyc / 4) - 1) % 3 == s)));
  endtask

  task automatic check_slot(input string tag, input int s, input logic [2:0] exp_an,
                            input logic [6:0] exp_seg);
    wait_slot(s);
    check({tag, "_an"},  {13'd0, an},  {13'd0, exp_an});
    check({tag, "_seg"}, {9'd0, seg},  {9'd0, exp_seg});
  endtask

  initial begin
    rst         = 1'b0;
    value_valid = 1'b0;
    value       = 8'd0;

    // Reset values while held.
    repeat (2) clk_edge();
    check("rst_seg",   {9'd0, seg},     16'h007F);
    check("rst_an",    {13'd0, an},     16'h0007);
    check("rst_ready", {15'd0, ready},  16'h0001);
    check("rst_bcd",   {4'd0, digits_bcd}, 16'h0000);

    // Release away from the edge; first tick on edge 4 shows digit 0.
    rst = 1'b1;
    cyc = 0;
    repeat (3) clk_edge();
    check("pre_tick_an",  {13'd0, an}, 16'h0007);
    check("pre_tick_seg", {9'd0, seg}, 16'h007F);
    clk_edge();
    check("tick1_an",  {13'd0, an}, 16'h0006);
    check("tick1_seg", {9'd0, seg}, 16'h0001);

    // Latency: ready low through e0+8, result and ready on e0+9.
    accept(8'd255);
    for (int i = 1; i <= 8; i++) begin
      clk_edge();
      check("busy_ready", {15'd0, ready}, 16'h0000);
    end
    check("busy_hold", {4'd0, digits_bcd}, 16'h0000);
    clk_edge();
    check("lat_ready", {15'd0, ready},      16'h0001);
    check("lat_bcd",   {4'd0, digits_bcd},  16'h0255);

    // Scan order and wrap.
    accept(8'd123);
    wait_ready();
    check("scan_bcd", {4'd0, digits_bcd}, 16'h0123);
    check_slot("scan0", 0, 3'b110, 7'h06);
    check_slot("scan1", 1, 3'b101, 7'h12);
    check_slot("scan2", 2, 3'b011, 7'h4F);
    wait_slot(0);
    check("scan_wrap_an", {13'd0, an}, 16'h0006);

    // Leading-zero blanking.
    accept(8'd7);
    wait_ready();
    check("blank7_bcd", {4'd0, digits_bcd}, 16'h0007);
    check_slot("blank7_s0", 0, 3'b110, 7'h0F);
    check_slot("blank7_s1", 1, 3'b101, 7'h7F);
    check_slot("blank7_s2", 2, 3'b011, 7'h7F);

    accept(8'd0);
    wait_ready();
    check("blank0_bcd", {4'd0, digits_bcd}, 16'h0000);
    check_slot("blank0_s0", 0, 3'b110, 7'h01);
    check_slot("blank0_s1", 1, 3'b101, 7'h7F);
    check_slot("blank0_s2", 2, 3'b011, 7'h7F);

    accept(8'd105);
    wait_ready();
    check("mid0_bcd", {4'd0, digits_bcd}, 16'h0105);
    check_slot("mid0_s0", 0, 3'b110, 7'h24);
    check_slot("mid0_s1", 1, 3'b101, 7'h01);
    check_slot("mid0_s2", 2, 3'b011, 7'h4F);

    // Request while busy is dropped, not queued.
    accept(8'd200);
    repeat (2) clk_edge();
    value_valid = 1'b1;
    value       = 8'd45;
    clk_edge();
    value_valid = 1'b0;
    wait_ready();
    check("drop_bcd", {4'd0, digits_bcd}, 16'h0200);
    repeat (3) clk_edge();
    check("drop_noqueue", {4'd0, digits_bcd}, 16'h0200);
    accept(8'd45);
    wait_ready();
    check("rereq_bcd", {4'd0, digits_bcd}, 16'h0045);

    // Reset mid-conversion aborts and clears everything.
    accept(8'd99);
    repeat (4) clk_edge();
    rst = 1'b0;
    #1;
    check("abort_bcd",   {4'd0, digits_bcd}, 16'h0000);
    check("abort_ready", {15'd0, ready},     16'h0001);
    check("abort_seg",   {9'd0, seg},        16'h007F);
    check("abort_an",    {13'd0, an},        16'h0007);
    clk_edge();
    check("abort_hold_bcd", {4'd0, digits_bcd}, 16'h0000);
    rst = 1'b1;
    cyc = 0;
    accept(8'd99);
    wait_ready();
    check("after_abort_bcd", {4'd0, digits_bcd}, 16'h0099);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
